// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states and error codes.
package mem_write_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/mem_write_checker_expect_table.sv
// Expected-write table: DEPTH entries of {addr, data}, one sync write port,
// one async read port, async active-low clear.
module mwc_expect_table #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [ADDR_W-1:0] raddr_o,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned IW1 = IDX_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              wr_ok;
  logic              rd_ok;

  // Indices beyond DEPTH are only reachable when DEPTH is not a power of two.
  assign wr_ok = {1'b0, widx_i} < IW1'(DEPTH);
  assign rd_ok = {1'b0, ridx_i} < IW1'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (we_i && wr_ok) begin
      addr_q[widx_i] <= waddr_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign raddr_o = rd_ok ? addr_q[ridx_i] : '0;
  assign rdata_o = rd_ok ? data_q[ridx_i] : '0;

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor for the core's data-memory write port: compares writes
// against an ordered table of expected writes and reports pass/fail/timeout.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned STRICT  = 1,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W:0]    cfg_count,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        err_code,
  output logic [IDX_W-1:0]  err_index,
  output logic [CNT_W-1:0]  writes_seen,
  output logic [CNT_W-1:0]  stray_cnt
);

  localparam int unsigned CIW   = IDX_W + 1;
  localparam int unsigned CYC_W = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [1:0]        err_d;
  logic [IDX_W:0]    count_q, count_in;
  logic [IDX_W-1:0]  ptr_q;
  logic [CYC_W-1:0]  cycles_q;
  logic              busy_q, pass_q, fail_q;
  logic [1:0]        err_code_q;
  logic [IDX_W-1:0]  err_index_q;
  logic [CNT_W-1:0]  writes_q, stray_q;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              hit, last, timeout;

  mwc_expect_table #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (cfg_we && (state_q == ST_IDLE)),
    .widx_i  (cfg_idx),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .ridx_i  (ptr_q),
    .raddr_o (exp_addr),
    .rdata_o (exp_data)
  );

  assign count_in = (cfg_count > CIW'(DEPTH)) ? CIW'(DEPTH) : cfg_count;
  assign hit      = (data_adr == exp_addr) && (write_data == exp_data);
  assign last     = {1'b0, ptr_q} == (count_q - CIW'(1));
  assign timeout  = cycles_q == CYC_W'(TIMEOUT - 1);

  // Priority in RUN: completing match, then mismatch, then timeout.
  always_comb begin
    state_d = state_q;
    err_d   = ERR_NONE;
    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) state_d = (count_in == '0) ? ST_PASS : ST_RUN;
      end
      ST_RUN: begin
        if (mem_write && hit && last) begin
          state_d = ST_PASS;
        end else if (mem_write && !hit && (STRICT != 0)) begin
          state_d = ST_FAIL;
          err_d   = ERR_MISMATCH;
        end else if (timeout) begin
          state_d = ST_FAIL;
          err_d   = ERR_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      count_q     <= '0;
      ptr_q       <= '0;
      cycles_q    <= '0;
      err_code_q  <= ERR_NONE;
      err_index_q <= '0;
      writes_q    <= '0;
      stray_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d == ST_RUN;
      pass_q  <= state_d == ST_PASS;
      fail_q  <= state_d == ST_FAIL;
      if (state_q != ST_RUN) begin
        if (start) begin
          count_q     <= count_in;
          ptr_q       <= '0;
          cycles_q    <= '0;
          writes_q    <= '0;
          stray_q     <= '0;
          err_code_q  <= ERR_NONE;
          err_index_q <= '0;
        end
      end else begin
        cycles_q <= cycles_q + CYC_W'(1);
        if (mem_write) begin
          if (writes_q != '1) writes_q <= writes_q + CNT_W'(1);
          if (hit) begin
            ptr_q <= ptr_q + IDX_W'(1);
          end else if ((STRICT == 0) && (stray_q != '1)) begin
            stray_q <= stray_q + CNT_W'(1);
          end
        end
        if (state_d == ST_FAIL) begin
          err_code_q  <= err_d;
          err_index_q <= ptr_q;
        end
      end
    end
  end

  assign busy        = busy_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_code    = err_code_q;
  assign err_index   = err_index_q;
  assign writes_seen = writes_q;
  assign stray_cnt   = stray_q;

endmodule
